// File: rtl/tdc_thermo_decoder_pkg.sv
// Shared types for the TDC thermometer decoder: FSM states, fine-width helper
// and the {coarse, fine, saturated} timestamp record.
package tdc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } tdc_state_e;

    // Widest coarse/fine fields any configuration may carry in a timestamp record
    localparam int TS_COARSE_MAX = 32;
    localparam int TS_FINE_MAX   = 16;

    typedef struct packed {
        logic [TS_COARSE_MAX-1:0] coarse;
        logic [TS_FINE_MAX-1:0]   fine;
        logic                     saturated;
    } tdc_ts_t;

    function automatic int fine_width(input int n_taps);
        return $clog2(n_taps + 1);
    endfunction

endpackage

// File: rtl/tdc_thermo_decoder_if.sv
// Timestamp readout channel: valid/ready handshake carrying fine, coarse and
// saturation flag from the decoder (master) to downstream readout (slave).
interface tdc_thermo_decoder_if #(
    parameter int FINE_W   = 7,
    parameter int COARSE_W = 24
);
    logic                out_valid;
    logic                out_ready;
    logic [FINE_W-1:0]   out_fine;
    logic [COARSE_W-1:0] out_coarse;
    logic                out_saturated;

    modport master (
        output out_valid,
        output out_fine,
        output out_coarse,
        output out_saturated,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_fine,
        input  out_coarse,
        input  out_saturated,
        output out_ready
    );
endinterface

// File: rtl/tdc_thermo_decoder_bubble_fix.sv
// Combinational majority-of-3 bubble corrector for the sampled thermometer code.
// Only built when TDC_BUBBLE_FIX_EN is defined.
`ifdef TDC_BUBBLE_FIX_EN
module tdc_bubble_fix #(
    parameter int TAPS = 64
) (
    input  logic [TAPS-1:0] t_i,
    output logic [TAPS-1:0] c_o
);
    // ext[i] is t[i-1]; the chain is padded with a 1 before the entry and a 0 past the end
    logic [TAPS+1:0] ext;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign ext = {1'b0, t_i, 1'b1};

    always_comb begin
        c_o = '0;
        for (int i = 0; i < TAPS; i++) begin
            c_o[i] = maj3(ext[i], ext[i+1], ext[i+2]);
        end
    end
endmodule
`endif

// File: rtl/tdc_thermo_decoder.sv
// Carry-chain TDC reader: hit detect, stage-1 correction (majority fix when
// TDC_BUBBLE_FIX_EN is defined, plain register otherwise), popcount, 1-entry output.
module tdc_thermo_decoder
    import tdc_pkg::*;
#(
    parameter int TAPS     = 64,
    parameter int COARSE_W = 24,
    parameter int OVF_W    = 16
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 clken,
    input  logic [TAPS-1:0]      taps,
    tdc_thermo_decoder_if.master out_if,
    output logic [OVF_W-1:0]     overflow_cnt,
    output logic                 busy
);
    localparam int FINE_W = fine_width(TAPS);

    tdc_state_e          state_q, state_d;
    logic                prev_tap0_q;
    logic [COARSE_W-1:0] coarse_q;
    logic                hit;

    logic                vld_p0_q, vld_p1_q, vld_p2_q;
    logic [TAPS-1:0]     taps_p0_q;
    logic [TAPS-1:0]     corr_p1_d, corr_p1_q;
    logic [FINE_W-1:0]   fine_p2_d, fine_p2_q;
    logic [COARSE_W-1:0] coarse_p0_q, coarse_p1_q, coarse_p2_q;

    logic                out_valid_q, out_valid_d;
    logic [FINE_W-1:0]   out_fine_q;
    logic [COARSE_W-1:0] out_coarse_q;
    logic                out_sat_q;
    logic [OVF_W-1:0]    ovf_q;
    logic                drain, arrive, accept, drop;

    function automatic logic [FINE_W-1:0] popcount(input logic [TAPS-1:0] v);
        logic [FINE_W-1:0] n;
        n = '0;
        for (int i = 0; i < TAPS; i++) begin
            n = n + FINE_W'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (taps[0] && !prev_tap0_q) begin
                    hit     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!taps[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // prev_tap0 resets high so a chain already full at reset release is not a hit
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q     <= IDLE;
            prev_tap0_q <= 1'b1;
            coarse_q    <= '0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
        end else if (clken) begin
            state_q     <= state_d;
            prev_tap0_q <= taps[0];
            coarse_q    <= coarse_q + COARSE_W'(1);
            vld_p0_q    <= hit;
            vld_p1_q    <= vld_p0_q;
            vld_p2_q    <= vld_p1_q;
        end
    end

    // ---- stage 0 -> 1: thermometer correction ----
`ifdef TDC_BUBBLE_FIX_EN
    tdc_bubble_fix #(.TAPS(TAPS)) u_bubble_fix (
        .t_i (taps_p0_q),
        .c_o (corr_p1_d)
    );
`else
    assign corr_p1_d = taps_p0_q;
`endif

    // ---- stage 1 -> 2: population count ----
    assign fine_p2_d = popcount(corr_p1_q);

    always_ff @(posedge clock) begin
        if (clken) begin
            if (hit) begin
                taps_p0_q   <= taps;
                coarse_p0_q <= coarse_q;
            end
            corr_p1_q   <= corr_p1_d;
            coarse_p1_q <= coarse_p0_q;
            fine_p2_q   <= fine_p2_d;
            coarse_p2_q <= coarse_p1_q;
        end
    end

    // ---- stage 2 -> output register ----
    // Draining is allowed even while clken is low; new results only move with clken.
    always_comb begin
        drain       = out_valid_q & out_if.out_ready;
        arrive      = clken & vld_p2_q;
        accept      = arrive & (~out_valid_q | drain);
        drop        = arrive & out_valid_q & ~drain;
        out_valid_d = accept | (out_valid_q & ~drain);
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            out_valid_q  <= 1'b0;
            out_fine_q   <= '0;
            out_coarse_q <= '0;
            out_sat_q    <= 1'b0;
            ovf_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_fine_q   <= fine_p2_q;
                out_coarse_q <= coarse_p2_q;
                out_sat_q    <= (fine_p2_q == FINE_W'(TAPS));
            end
            if (drop && (ovf_q != '1)) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
        end
    end

    assign out_if.out_valid     = out_valid_q;
    assign out_if.out_fine      = out_fine_q;
    assign out_if.out_coarse    = out_coarse_q;
    assign out_if.out_saturated = out_sat_q;
    assign overflow_cnt         = ovf_q;
    assign busy = (state_q != IDLE) | vld_p0_q | vld_p1_q | vld_p2_q | out_valid_q;

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Directed bench for tdc_thermo_decoder: dut_a uses the default 24-bit coarse
// counter, dut_b a 4-bit one for the wrap scenario; both share clock and stimulus.
`timescale 1ns/1ps
module tb_tdc_thermo_decoder;
    import tdc_pkg::*;

    localparam int TAPS      = 64;
    localparam int FINE_W    = 7;
    localparam int COARSE_W  = 24;
    localparam int COARSE_WB = 4;
    localparam int OVF_W     = 16;
`ifdef TDC_BUBBLE_FIX_EN
    localparam int EXP_BUB = 20;
`else
    localparam int EXP_BUB = 19;
`endif

    logic            clock = 1'b0;
    logic            aclr_n;
    logic            clken;
    logic [TAPS-1:0] taps;
    logic [OVF_W-1:0] ovf_a, ovf_b;
    logic            busy_a, busy_b;

    int checks     = 0;
    int failures   = 0;
    int exp_coarse = 0;

    tdc_thermo_decoder_if #(.FINE_W(FINE_W), .COARSE_W(COARSE_W))  if_a ();
    tdc_thermo_decoder_if #(.FINE_W(FINE_W), .COARSE_W(COARSE_WB)) if_b ();

    tdc_thermo_decoder #(.TAPS(TAPS), .COARSE_W(COARSE_W), .OVF_W(OVF_W)) dut_a (
        .clock(clock), .aclr_n(aclr_n), .clken(clken), .taps(taps),
        .out_if(if_a), .overflow_cnt(ovf_a), .busy(busy_a)
    );

    tdc_thermo_decoder #(.TAPS(TAPS), .COARSE_W(COARSE_WB), .OVF_W(OVF_W)) dut_b (
        .clock(clock), .aclr_n(aclr_n), .clken(clken), .taps(taps),
        .out_if(if_b), .overflow_cnt(ovf_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic tick();
        if (clken && aclr_n) exp_coarse++;
        @(posedge clock);
        #1;
    endtask

    task automatic set_ready(input logic r);
        if_a.out_ready = r;
        if_b.out_ready = r;
    endtask

    task automatic do_reset(input logic [TAPS-1:0] t);
        aclr_n = 1'b0;
        taps   = t;
        clken  = 1'b1;
        set_ready(1'b1);
        tick();
        tick();
        aclr_n     = 1'b1;
        exp_coarse = 0;
    endtask

    task automatic wait_coarse(input int c);
        for (int i = 0; i < 300 && exp_coarse != c; i++) tick();
    endtask

    task automatic pulse(input logic [TAPS-1:0] t);
        taps = t;
        tick();
        taps = '0;
        tick();
    endtask

    task automatic test_reset();
        aclr_n = 1'b0;
        taps   = '1;
        clken  = 1'b1;
        set_ready(1'b1);
        #3;
        checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", if_a.out_valid); end
        checks++; if (if_a.out_fine !== 7'd0) begin failures++; $display("FAIL reset_fine got=%0d want=0", if_a.out_fine); end
        checks++; if (if_a.out_coarse !== 24'd0) begin failures++; $display("FAIL reset_coarse got=%0d want=0", if_a.out_coarse); end
        checks++; if (if_a.out_saturated !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b want=0", if_a.out_saturated); end
        checks++; if (ovf_a !== 16'd0) begin failures++; $display("FAIL reset_ovf got=%0d want=0", ovf_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy_a); end
        do_reset('0);
        tick();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b want=0", busy_a); end
    endtask

    task automatic test_fine20();
        wait_coarse(100);
        pulse(64'h0000_0000_000F_FFFF);
        tick();
        checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL f20_early got=%0b want=0", if_a.out_valid); end
        tick();
        checks++; if (if_a.out_valid !== 1'b1) begin failures++; $display("FAIL f20_valid got=%0b want=1", if_a.out_valid); end
        checks++; if (if_a.out_fine !== 7'd20) begin failures++; $display("FAIL f20_fine got=%0d want=20", if_a.out_fine); end
        checks++; if (if_a.out_coarse !== 24'd100) begin failures++; $display("FAIL f20_coarse got=%0d want=100", if_a.out_coarse); end
        checks++; if (if_a.out_saturated !== 1'b0) begin failures++; $display("FAIL f20_sat got=%0b want=0", if_a.out_saturated); end
        tick();
        checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL f20_drain got=%0b want=0", if_a.out_valid); end
    endtask

    task automatic test_bubble();
        logic [TAPS-1:0] pat;
        int c0;
        pat = 64'h0000_0000_000F_FFFF;
        pat[5] = 1'b0;
        c0 = exp_coarse;
        pulse(pat);
        tick();
        tick();
        checks++; if (if_a.out_valid !== 1'b1) begin failures++; $display("FAIL bub_valid got=%0b want=1", if_a.out_valid); end
        checks++; if (if_a.out_fine !== 7'(EXP_BUB)) begin failures++; $display("FAIL bub_fine got=%0d want=%0d", if_a.out_fine, EXP_BUB); end
        checks++; if (if_a.out_coarse !== 24'(c0)) begin failures++; $display("FAIL bub_coarse got=%0d want=%0d", if_a.out_coarse, c0); end
        tick();
    endtask

    task automatic test_saturation();
        pulse('1);
        tick();
        tick();
        checks++; if (if_a.out_valid !== 1'b1) begin failures++; $display("FAIL sat_valid got=%0b want=1", if_a.out_valid); end
        checks++; if (if_a.out_fine !== 7'd64) begin failures++; $display("FAIL sat_fine got=%0d want=64", if_a.out_fine); end
        checks++; if (if_a.out_saturated !== 1'b1) begin failures++; $display("FAIL sat_flag got=%0b want=1", if_a.out_saturated); end
        tick();
    endtask

    task automatic test_backpressure();
        int ca, xfers;
        logic [FINE_W-1:0] got_fine;
        set_ready(1'b0);
        ca = exp_coarse;
        taps = 64'hFF;
        tick();
        taps = '0;
        tick();
        tick();
        tick();
        taps = 64'hFFFF;
        tick();
        taps = '0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (ovf_a !== 16'd1) begin failures++; $display("FAIL bp_ovf got=%0d want=1", ovf_a); end
        checks++; if (if_a.out_valid !== 1'b1) begin failures++; $display("FAIL bp_held got=%0b want=1", if_a.out_valid); end
        checks++; if (if_a.out_fine !== 7'd8) begin failures++; $display("FAIL bp_fine got=%0d want=8", if_a.out_fine); end
        checks++; if (if_a.out_coarse !== 24'(ca)) begin failures++; $display("FAIL bp_coarse got=%0d want=%0d", if_a.out_coarse, ca); end
        set_ready(1'b1);
        xfers = 0;
        got_fine = '0;
        for (int i = 0; i < 6; i++) begin
            if (if_a.out_valid && if_a.out_ready) begin
                xfers++;
                got_fine = if_a.out_fine;
            end
            tick();
        end
        checks++; if (xfers != 1) begin failures++; $display("FAIL bp_xfers got=%0d want=1", xfers); end
        checks++; if (got_fine !== 7'd8) begin failures++; $display("FAIL bp_xfer_fine got=%0d want=8", got_fine); end
        checks++; if (ovf_a !== 16'd1) begin failures++; $display("FAIL bp_ovf_keep got=%0d want=1", ovf_a); end
    endtask

    task automatic test_stuck_high();
        int nv;
        logic [FINE_W-1:0] f;
        do_reset('1);
        checks++; if (ovf_a !== 16'd0) begin failures++; $display("FAIL stk_ovf_clr got=%0d want=0", ovf_a); end
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if_a.out_valid) nv++;
        end
        checks++; if (nv != 0) begin failures++; $display("FAIL stk_nohit got=%0d want=0", nv); end
        taps = '0;
        tick();
        taps = '1;
        nv = 0;
        f = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if_a.out_valid) begin
                nv++;
                f = if_a.out_fine;
            end
        end
        checks++; if (nv != 1) begin failures++; $display("FAIL stk_onehit got=%0d want=1", nv); end
        checks++; if (f !== 7'd64) begin failures++; $display("FAIL stk_fine got=%0d want=64", f); end
        taps = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int nv;
        pulse(64'hFF);
        aclr_n = 1'b0;
        #2;
        aclr_n = 1'b1;
        exp_coarse = 0;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (if_a.out_valid) nv++;
        end
        checks++; if (nv != 0) begin failures++; $display("FAIL rmid_discard got=%0d want=0", nv); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b want=0", busy_a); end
    endtask

    task automatic test_coarse_wrap();
        tdc_ts_t got_b[$];
        int      got_a[$];
        tdc_ts_t ts;
        do_reset('0);
        wait_coarse(15);
        for (int i = 0; i < 12; i++) begin
            taps = (i == 0 || i == 3) ? 64'h0F : '0;
            tick();
            if (if_b.out_valid) begin
                ts = '0;
                ts.coarse = 32'(if_b.out_coarse);
                ts.fine   = 16'(if_b.out_fine);
                got_b.push_back(ts);
            end
            if (if_a.out_valid) got_a.push_back(int'(if_a.out_coarse));
        end
        checks++; if (got_b.size() != 2) begin failures++; $display("FAIL wrap_count got=%0d want=2", got_b.size()); end
        if (got_b.size() == 2) begin
            checks++; if (got_b[0].coarse !== 32'd15) begin failures++; $display("FAIL wrap_first got=%0d want=15", got_b[0].coarse); end
            checks++; if (got_b[1].coarse !== 32'd2) begin failures++; $display("FAIL wrap_second got=%0d want=2", got_b[1].coarse); end
            checks++; if (got_b[1].fine !== 16'd4) begin failures++; $display("FAIL wrap_fine got=%0d want=4", got_b[1].fine); end
        end
        checks++; if (got_a.size() != 2) begin failures++; $display("FAIL wide_count got=%0d want=2", got_a.size()); end
        if (got_a.size() == 2) begin
            checks++; if (got_a[1] != 18) begin failures++; $display("FAIL wide_second got=%0d want=18", got_a[1]); end
        end
    endtask

    task automatic test_clken_stall();
        int c0, early;
        c0 = exp_coarse;
        taps = 64'h0000_0000_000F_FFFF;
        tick();
        taps = '0;
        clken = 1'b0;
        early = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (if_a.out_valid) early++;
        end
        clken = 1'b1;
        tick();
        tick();
        if (if_a.out_valid) early++;
        checks++; if (early != 0) begin failures++; $display("FAIL stall_early got=%0d want=0", early); end
        tick();
        checks++; if (if_a.out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%0b want=1", if_a.out_valid); end
        checks++; if (if_a.out_fine !== 7'd20) begin failures++; $display("FAIL stall_fine got=%0d want=20", if_a.out_fine); end
        checks++; if (if_a.out_coarse !== 24'(c0)) begin failures++; $display("FAIL stall_coarse got=%0d want=%0d", if_a.out_coarse, c0); end
        tick();

        set_ready(1'b0);
        pulse(64'hFF);
        tick();
        tick();
        clken = 1'b0;
        tick();
        checks++; if (if_a.out_valid !== 1'b1) begin failures++; $display("FAIL frz_hold got=%0b want=1", if_a.out_valid); end
        set_ready(1'b1);
        tick();
        checks++; if (if_a.out_valid !== 1'b0) begin failures++; $display("FAIL frz_drain got=%0b want=0", if_a.out_valid); end
        clken = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fine20();
        test_bubble();
        test_saturation();
        test_backpressure();
        test_stuck_high();
        test_reset_mid();
        test_coarse_wrap();
        test_clken_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdc_thermo_decoder.md
Name: tdc_thermo_decoder

Overview:
Reader end of the carry-chain delay line. It takes the per-clock sample of the TDC carry-chain taps, which is a thermometer code, and detects each new hit. It converts the sampled code to a fine count and latches a free-running coarse count for the same cycle. Each result is handed to downstream readout as a {coarse, fine} timestamp over a valid/ready handshake.

Parameters:
TAPS, 64, number of carry-chain taps sampled per clock (>=4)
COARSE_W, 24, width of the internal coarse counter
FINE_W, $clog2(TAPS+1), derived localparam; width of the fine count (0..TAPS)
OVF_W, 16, width of the saturating dropped-hit counter

Ports:
clock  in  1  single system clock; also samples the chain
aclr_n  in  1  asynchronous active-low reset
clken  in  1  clock enable; when low, all state is frozen and taps are ignored
taps  in  TAPS  sampled carry-chain outputs; taps[0] is the chain entry
out_valid  out  1  timestamp available
out_ready  in  1  downstream accepts the timestamp
out_fine  out  FINE_W  ones count of the corrected thermometer word
out_coarse  out  COARSE_W  coarse count at the hit-detect cycle
out_saturated  out  1  fine == TAPS; the hit travelled past the chain end
overflow_cnt  out  OVF_W  number of hits dropped because of backpressure; saturates
busy  out  1  FSM not in IDLE, or a result is in flight

Behaviour:
Reset (aclr_n low, async):
- All outputs are 0; state is IDLE.
- The prev_tap0 register resets to 1, so a chain stuck high at reset release gives no hit.
- coarse counter resets to 0.

Coarse counter:
- Increments by 1 on every clock with clken=1.
- Wraps modulo 2^COARSE_W.

Hit detect (cycle 0):
- A hit is taps[0]==1 && prev_tap0==0 && state==IDLE.
- On a hit, register taps into s0 together with the coarse value of that cycle.

FSM:
- IDLE -> HOLD on hit.
- HOLD -> IDLE on the first sample with taps[0]==0.
- Minimum spacing between hits is 2 clocks.

Pipeline (fully pipelined; several hits may be in flight):
- Stage 1: bubble correction (see Optional Feature).
- Stage 2: population count -> fine.
- out_valid rises 3 clocks after the hit cycle, provided the output register is free.

Output register (single entry):
- Holds fine, coarse and saturated while out_valid && !out_ready.
- The transfer happens on out_valid && out_ready.
- If a stage-2 result arrives while the register is occupied and not being drained that cycle, the result is dropped and overflow_cnt increments (saturating at all ones).
- A result that arrives in the same cycle as a drain is accepted; there is no bubble.

clken=0:
- Pipeline, FSM, counters and prev_tap0 all hold.
- out_valid stays asserted and is still drainable.

Reset mid-operation:
- In-flight results are discarded and no output is produced.
- Re-arming requires taps[0]==0 to be sampled first.

Optional Feature:
Macro TDC_BUBBLE_FIX_EN.
- Defined: stage 1 computes c[i] = majority(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[TAPS]=0. Isolated bubbles are removed.
- Undefined: stage 1 is a plain register, c = t, and the popcount runs on the raw code.
- Latency is 3 clocks in both cases.

Decomposition:
Shared package tdc_pkg holds:
- the state enum {IDLE, HOLD}
- the fine_width(taps) function
- the timestamp struct {coarse, fine, saturated}

The natural sub-module is tdc_bubble_fix: the combinational majority-of-3 corrector, instantiated only when TDC_BUBBLE_FIX_EN is defined.

Test Plan:
- Hit with 20 ones: taps = 0, then taps = 64'h0000_0000_000F_FFFF at coarse 100 -> 3 clocks later out_valid=1, out_fine=20, out_coarse=100, out_saturated=0.
- Single bubble: as above with bit 5 cleared -> out_fine=20 with TDC_BUBBLE_FIX_EN defined; out_fine=19 without.
- Saturation: taps goes 0 -> all ones -> out_fine=64, out_saturated=1.
- Backpressure: out_ready=0 and two hits 4 clocks apart -> the first is held, the second is dropped and overflow_cnt=1; then raise out_ready -> exactly one transfer with the first timestamp.
- Stuck high at reset: taps all ones from before aclr_n rises -> no out_valid; then taps=0 for 1 clock and ones again -> one hit is reported.
- Coarse wrap and clken: with COARSE_W=4, hit at count 15 and a second hit after the wrap at count 2 -> out_coarse=15, then 2. clken=0 for 5 clocks mid-pipeline -> latency stretches by 5 and the values are unchanged.
